// File: rtl/ups_ca4l_regbank.sv
// ups_ca4l_regbank: AXI4-Lite slave register bank on the ca4l PS master port.
//   NUM_CTRL read/write control words followed by NUM_STAT read-only status words.
//   Byte strobes on writes, AW and W captured independently, SLVERR for stat/unmapped writes.
// Ports:
//   fclk, rstb                  clock, async active-low reset
//   ca4l_aw*/w*/b*/ar*/r*       AXI4-Lite slave channels (awprot/arprot ignored)
//   ctrl_o                      control words, word k at [k*DATA_W +: DATA_W]
//   ctrl_wr_o                   1-cycle pulse per control word written with OKAY
//   stat_i                      status words, sampled at the AR handshake
//   stat_rd_o                   1-cycle pulse per status word read
//   led                         low LED_W bits of control word 0
module ups_ca4l_regbank #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_CTRL = 8,
    parameter int unsigned       NUM_STAT = 8,
    parameter int unsigned       LED_W    = 4,
    parameter logic [DATA_W-1:0] CTRL_RST = '0
) (
    input  logic                                             fclk,
    input  logic                                             rstb,
    input  logic [ADDR_W-1:0]                                ca4l_awaddr,
    input  logic [2:0]                                       ca4l_awprot,
    input  logic                                             ca4l_awvalid,
    output logic                                             ca4l_awready,
    input  logic [DATA_W-1:0]                                ca4l_wdata,
    input  logic [DATA_W/8-1:0]                              ca4l_wstrb,
    input  logic                                             ca4l_wvalid,
    output logic                                             ca4l_wready,
    output logic [1:0]                                       ca4l_bresp,
    output logic                                             ca4l_bvalid,
    input  logic                                             ca4l_bready,
    input  logic [ADDR_W-1:0]                                ca4l_araddr,
    input  logic [2:0]                                       ca4l_arprot,
    input  logic                                             ca4l_arvalid,
    output logic                                             ca4l_arready,
    output logic [DATA_W-1:0]                                ca4l_rdata,
    output logic [1:0]                                       ca4l_rresp,
    output logic                                             ca4l_rvalid,
    input  logic                                             ca4l_rready,
    output logic [NUM_CTRL*DATA_W-1:0]                       ctrl_o,
    output logic [NUM_CTRL-1:0]                              ctrl_wr_o,
    input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*DATA_W-1:0] stat_i,
    output logic [((NUM_STAT > 0) ? NUM_STAT : 1)-1:0]       stat_rd_o,
    output logic [LED_W-1:0]                                 led
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned NUM_W    = NUM_CTRL + NUM_STAT;
    localparam int unsigned IDX_W    = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam int unsigned STAT_N   = (NUM_STAT > 0) ? NUM_STAT : 1;
    localparam logic [1:0]  RESP_OK  = 2'b00;
    localparam logic [1:0]  RESP_ERR = 2'b10;

    // Word index within the aliased window; a single-word bank decodes everything to word 0.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        if (NUM_W == 1) return '0;
        return a[ADDR_LSB +: IDX_W];
    endfunction

    logic                r_run;
    logic                r_aw_held;
    logic [IDX_W-1:0]    r_aw_idx;
    logic                r_w_held;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic [DATA_W-1:0]   r_ctrl [NUM_CTRL];
    logic [NUM_CTRL-1:0] r_wr_pulse;
    logic [STAT_N-1:0]   r_rd_pulse;

    logic                w_awready;
    logic                w_wready;
    logic                w_arready;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_commit;
    logic [IDX_W-1:0]    w_cm_idx;
    logic [DATA_W-1:0]   w_cm_data;
    logic [STRB_W-1:0]   w_cm_strb;
    logic                w_cm_ctrl;
    logic [NUM_CTRL-1:0] w_cm_sel;
    logic [IDX_W-1:0]    w_ar_idx;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_rd_err;
    logic [STAT_N-1:0]   w_rd_stat;
    logic                w_unused;

    assign w_awready = r_run & ~r_aw_held & ~r_bvalid;
    assign w_wready  = r_run & ~r_w_held & ~r_bvalid;
    assign w_arready = r_run & ~r_rvalid;
    assign w_aw_hs   = ca4l_awvalid & w_awready;
    assign w_w_hs    = ca4l_wvalid & w_wready;
    assign w_ar_hs   = ca4l_arvalid & w_arready;

    // Commit as soon as both halves are present, whether held from earlier or arriving now.
    assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_cm_idx  = r_aw_held ? r_aw_idx : addr_idx(ca4l_awaddr);
    assign w_cm_data = r_w_held ? r_wdata : ca4l_wdata;
    assign w_cm_strb = r_w_held ? r_wstrb : ca4l_wstrb;
    assign w_cm_ctrl = 32'(w_cm_idx) < NUM_CTRL;
    assign w_ar_idx  = addr_idx(ca4l_araddr);

    // One-hot select of the control word targeted by a commit.
    always_comb begin
        w_cm_sel = '0;
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            w_cm_sel[k] = w_commit & (32'(w_cm_idx) == k);
        end
    end

    // Read mux; reads the control words before any same-edge write lands.
    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b1;
        w_rd_stat = '0;
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            if (32'(w_ar_idx) == k) begin
                w_rd_data = r_ctrl[k];
                w_rd_err  = 1'b0;
            end
        end
        for (int unsigned k = 0; k < NUM_STAT; k++) begin
            if (32'(w_ar_idx) == NUM_CTRL + k) begin
                w_rd_data    = stat_i[k*DATA_W +: DATA_W];
                w_rd_err     = 1'b0;
                w_rd_stat[k] = 1'b1;
            end
        end
    end

    // Readies held low through reset and for the first edge after release.
    always_ff @(posedge fclk or negedge rstb) begin
        if (!rstb) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    // AW/W holding registers and write response.
    always_ff @(posedge fclk or negedge rstb) begin
        if (!rstb) begin
            r_aw_held  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OK;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_aw_held  <= 1'b0;
                r_w_held   <= 1'b0;
                r_bvalid   <= 1'b1;
                r_bresp    <= w_cm_ctrl ? RESP_OK : RESP_ERR;
                r_wr_pulse <= w_cm_sel;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= addr_idx(ca4l_awaddr);
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= ca4l_wdata;
                    r_wstrb  <= ca4l_wstrb;
                end
                if (r_bvalid && ca4l_bready) r_bvalid <= 1'b0;
            end
        end
    end

    // Control words with byte-strobed update.
    always_ff @(posedge fclk or negedge rstb) begin
        if (!rstb) begin
            for (int unsigned k = 0; k < NUM_CTRL; k++) r_ctrl[k] <= CTRL_RST;
        end else begin
            for (int unsigned k = 0; k < NUM_CTRL; k++) begin
                if (w_cm_sel[k]) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (w_cm_strb[b]) r_ctrl[k][8*b +: 8] <= w_cm_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read response; data held until the R handshake.
    always_ff @(posedge fclk or negedge rstb) begin
        if (!rstb) begin
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OK;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= '0;
            if (w_ar_hs) begin
                r_rvalid   <= 1'b1;
                r_rdata    <= w_rd_data;
                r_rresp    <= w_rd_err ? RESP_ERR : RESP_OK;
                r_rd_pulse <= w_rd_stat;
            end else if (r_rvalid && ca4l_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl
        assign ctrl_o[k*DATA_W +: DATA_W] = r_ctrl[k];
    end

    assign ca4l_awready = w_awready;
    assign ca4l_wready  = w_wready;
    assign ca4l_arready = w_arready;
    assign ca4l_bvalid  = r_bvalid;
    assign ca4l_bresp   = r_bresp;
    assign ca4l_rvalid  = r_rvalid;
    assign ca4l_rdata   = r_rdata;
    assign ca4l_rresp   = r_rresp;
    assign ctrl_wr_o    = r_wr_pulse;
    assign stat_rd_o    = r_rd_pulse;
    assign led          = r_ctrl[0][LED_W-1:0];

    // Protection bits and address bits above the decode window are intentionally ignored.
    assign w_unused = ^{ca4l_awprot, ca4l_arprot, ca4l_awaddr, ca4l_araddr};

endmodule
